tdm_demux: RTL

//  Receive-side time-division demultiplexer; reverse direction of the channel mux.

---
 rtl/tdm_demux.sv | 110 +++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: rebuilds serial channel samples into parallel frames.
// Optional parity checking is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 1,
    localparam int CW    = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                    din_par,
    output logic                    par_err,
`endif
    output logic [NUM_CH*WIDTH-1:0] dout,
    output logic                    frame_valid,
    output logic [CW-1:0]           ch_idx,
    output logic                    locked,
    output logic                    sync_err
);

    typedef enum logic { S_HUNT, S_LOCKED } state_t;

    state_t                          state_q;
    logic [CW-1:0]                   ch_q;
    logic [NUM_CH-2:0][WIDTH-1:0]    shadow_q;
    logic [NUM_CH*WIDTH-1:0]         dout_q;
    logic                            frame_valid_q;
    logic                            sync_err_q;

`ifdef TDM_DEMUX_PARITY_EN
    logic par_bad;
    logic sticky_q;
    logic par_err_q;

    // din plus its parity bit must have an even number of ones
    assign par_bad = (^din) ^ din_par;
    assign par_err = par_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_HUNT;
            ch_q          <= '0;
            shadow_q      <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            sticky_q      <= 1'b0;
            par_err_q     <= 1'b0;
`endif
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q     <= 1'b0;
`endif
            if (din_valid) begin
                if (frame_sync) begin
                    // Frame start; any partial frame in flight is dropped
                    if (state_q == S_LOCKED && ch_q != '0)
                        sync_err_q <= 1'b1;
                    state_q     <= S_LOCKED;
                    shadow_q[0] <= din;
                    ch_q        <= CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
                    sticky_q    <= par_bad;
`endif
                end else if (state_q == S_LOCKED) begin
                    if (ch_q == '0) begin
                        sync_err_q <= 1'b1;
                        state_q    <= S_HUNT;
                        ch_q       <= '0;
                    end else if (ch_q == CW'(NUM_CH-1)) begin
                        ch_q <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                        if (sticky_q || par_bad) begin
                            par_err_q <= 1'b1;
                        end else begin
                            dout_q        <= {din, shadow_q};
                            frame_valid_q <= 1'b1;
                        end
`else
                        dout_q        <= {din, shadow_q};
                        frame_valid_q <= 1'b1;
`endif
                    end else begin
                        for (int k = 1; k < NUM_CH-1; k++)
                            if (ch_q == CW'(k))
                                shadow_q[k] <= din;
                        ch_q <= ch_q + CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
                        sticky_q <= sticky_q | par_bad;
`endif
                    end
                end
            end
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign ch_idx      = ch_q;
    assign locked      = (state_q == S_LOCKED);
    assign sync_err    = sync_err_q;

endmodule
